note_lane_engine: RTL and testbench
===================================

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 Parameter LANES, default 4, number of note lanes.
REQ-002 Parameter SLOTS, default 8, note slots per lane.
REQ-003 Parameter Y_W, default 10, width of a note vertical position.
REQ-004 Parameter SCREEN_H, default 480, y at which an unhit note expires.
REQ-005 Parameter NOTE_H, default 50, note height in pixels.
REQ-006 Parameter HIT_Y, default 350, and HIT_H, default 20: hit-line top and height.
REQ-007 Parameter SPEED, default 1, pixels advanced per tick.
REQ-008 Parameter POINTS, default 10, base score per hit.
REQ-009 Clock and reset: clk in 1, single system clock; reset_n in 1, asynchronous, active-low.
REQ-010 tick in 1: one-cycle frame strobe that advances notes.
REQ-011 spawn_valid in 1, spawn_lane in clog2(LANES), spawn_ready out 1: note-spawn handshake.
REQ-012 btn in LANES: per-lane player buttons, already synchronised to clk.
REQ-013 pix_y in Y_W: current scan line.
REQ-014 pix_in_note out LANES: bit l is high when pix_y lies inside any active note of lane l.
REQ-015 hit out LANES and miss out LANES: one-cycle event pulses.
REQ-016 score out 32: accumulated score.
REQ-017 combo out 16: current consecutive-hit count.

Function
REQ-018 Each lane SHALL hold SLOTS entries, each with a valid bit and a y position of Y_W bits.
REQ-019 spawn_ready SHALL be high when the lane selected by spawn_lane has at least one free slot.
REQ-020 A spawn SHALL occur on a cycle where spawn_valid and spawn_ready are both high; it SHALL fill the lowest-index free slot with y = 0, valid = 1.
REQ-021 A spawn to a full lane SHALL be ignored; no state changes.
REQ-022 On tick, every valid note SHALL advance by SPEED.
REQ-023 A note spawned in the same cycle as tick SHALL keep y = 0 and SHALL NOT advance that cycle.
REQ-024 Expiry: on tick, a valid note whose advanced y is >= SCREEN_H SHALL be freed; miss[l] SHALL pulse the next cycle and combo SHALL clear.
REQ-025 A button press is a rising edge of btn[l], detected against a registered copy of btn.
REQ-026 A note is hittable when [y, y+NOTE_H) overlaps [HIT_Y, HIT_Y+HIT_H).
REQ-027 On a press, if the lane has a hittable note, the lowest-index hittable slot SHALL be freed, hit[l] SHALL pulse the next cycle, combo SHALL increment (saturating at 16'hFFFF), and score SHALL increase by the hit value.
REQ-028 On a press with no hittable note, miss[l] SHALL pulse the next cycle and combo SHALL clear.
REQ-029 When a press and an expiry in the same lane coincide, the press SHALL be evaluated on the pre-tick positions first; the hit-freed slot SHALL NOT also expire.
REQ-030 When hits in several lanes occur in one cycle, all SHALL score: combo increments by the number of hits. Any miss in the same cycle SHALL clear combo after the increments are applied.
REQ-031 score SHALL wrap modulo 2^32.
REQ-032 pix_in_note SHALL be combinational from pix_y and the slot state: y <= pix_y < y+NOTE_H.

Reset
REQ-033 While reset_n is low, all slot valid bits, hit, miss, score, combo and the registered btn copy SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight notes immediately; the first press after release SHALL NOT produce a spurious edge from buttons already held.

Configuration
REQ-035 With macro NOTE_LANE_COMBO_MULT_EN defined, the hit value SHALL be POINTS * min(1 + combo/8, 4), using combo before the increment.
REQ-036 Without NOTE_LANE_COMBO_MULT_EN, the hit value SHALL be POINTS. combo is still maintained.

Verification
REQ-037 Spawn lane 0 nine times at SLOTS=8 -> spawn_ready low after the eighth spawn; the ninth is ignored.
REQ-038 Spawn lane 1, apply 480 ticks with no press -> miss[1] pulses once, combo = 0, slot freed.
REQ-039 Spawn lane 2, apply 310 ticks (y = 310 overlaps the hit line), press btn[2] -> hit[2] pulses, score = 10, combo = 1.
REQ-040 Press btn[3] with lane 3 empty -> miss[3] pulses, combo resets from 5 to 0, score unchanged.
REQ-041 With NOTE_LANE_COMBO_MULT_EN, combo = 8 and a hit -> score += 20; combo = 40 and a hit -> score += 40.
REQ-042 Pull reset_n low while notes are active and btn[0] is held; release -> all pix_in_note = 0, score = 0, and no hit or miss pulse until btn[0] has been released and pressed again.

Source files
------------

// File: rtl/note_lane_engine.sv
// note_lane_engine
//   Rhythm-game note lanes. Each lane owns SLOTS note slots (valid + y).
//   Notes spawn at y = 0, fall by SPEED on every tick and expire at
//   SCREEN_H. A rising edge on a lane button hits the lowest-index note
//   overlapping the hit line. A press that finds no such note counts as a
//   miss, and so does an expiry. Score and combo are accumulated from these
//   events.
//
//   Optional feature: define NOTE_LANE_COMBO_MULT_EN to scale each hit by a
//   combo multiplier, min(1 + combo/8, 4). Without it, every hit scores
//   POINTS.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   tick              one-cycle frame strobe; advances all notes
//   spawn_valid/ready spawn handshake. A spawn happens on a cycle where both
//                     are high. ready is combinational: the selected lane
//                     has a free slot.
//   spawn_lane        lane targeted by the spawn request
//   btn               per-lane buttons, already synchronous to clk
//   pix_y             current scan line
//   pix_in_note       per lane: pix_y lies inside an active note (combinational)
//   hit, miss         one-cycle event pulses, registered
//   score, combo      accumulated score (wraps) and consecutive-hit count
module note_lane_engine #(
  parameter int LANES    = 4,
  parameter int SLOTS    = 8,
  parameter int Y_W      = 10,
  parameter int SCREEN_H = 480,
  parameter int NOTE_H   = 50,
  parameter int HIT_Y    = 350,
  parameter int HIT_H    = 20,
  parameter int SPEED    = 1,
  parameter int POINTS   = 10,
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             spawn_valid,
  input  logic [LW-1:0]    spawn_lane,
  output logic             spawn_ready,
  input  logic [LANES-1:0] btn,
  input  logic [Y_W-1:0]   pix_y,
  output logic [LANES-1:0] pix_in_note,
  output logic [LANES-1:0] hit,
  output logic [LANES-1:0] miss,
  output logic [31:0]      score,
  output logic [15:0]      combo
);

  logic [LANES-1:0][SLOTS-1:0]          valid_q, valid_d;
  logic [LANES-1:0][SLOTS-1:0][Y_W-1:0] y_q, y_d;
  logic [LANES-1:0] btn_q, press;
  logic [LANES-1:0] hit_q, hit_d, miss_q, miss_d;
  logic             arm_q;
  logic [31:0]      score_q, score_d;
  logic [15:0]      combo_q, combo_d;
  logic [31:0]      hit_cnt, hit_val, combo_sum, y_adv;
  logic             found, spawn_done;

  function automatic logic hittable(input logic [Y_W-1:0] y);
    logic [31:0] yw;
    yw = 32'(y);
    return (yw < 32'(HIT_Y + HIT_H)) && ((yw + 32'(NOTE_H)) > 32'(HIT_Y));
  endfunction

  always_comb begin
    spawn_ready = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (LW'(l) == spawn_lane) spawn_ready = ~&valid_q[l];
  end

`ifdef NOTE_LANE_COMBO_MULT_EN
  logic [15:0] mult;
  always_comb begin
    mult = (combo_q >> 3) + 16'd1;
    if (mult > 16'd4) mult = 16'd4;
    hit_val = 32'(POINTS) * 32'(mult);
  end
`else
  assign hit_val = 32'(POINTS);
`endif

  // Order inside each lane: the press is evaluated on pre-tick positions.
  // The tick then only touches slots still valid after the hit. The spawn
  // goes last, into a slot that was free at the start of the cycle, so it
  // is never advanced in its own cycle.
  always_comb begin
    valid_d    = valid_q;
    y_d        = y_q;
    hit_d      = '0;
    miss_d     = '0;
    hit_cnt    = '0;
    found      = 1'b0;
    spawn_done = 1'b0;
    y_adv      = '0;
    // arm_q masks the first cycle after reset, so that a button already
    // held through reset does not look like a fresh edge.
    press      = btn & ~btn_q & {LANES{arm_q}};
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (press[l] && !found && valid_q[l][s] && hittable(y_q[l][s])) begin
          found         = 1'b1;
          valid_d[l][s] = 1'b0;
        end
      end
      if (press[l]) begin
        hit_d[l]  = found;
        miss_d[l] = ~found;
      end
      if (found) hit_cnt = hit_cnt + 32'd1;
      if (tick) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (valid_d[l][s]) begin
            y_adv = 32'(y_q[l][s]) + 32'(SPEED);
            if (y_adv >= 32'(SCREEN_H)) begin
              valid_d[l][s] = 1'b0;
              miss_d[l]     = 1'b1;
            end else begin
              y_d[l][s] = y_adv[Y_W-1:0];
            end
          end
        end
      end
      if (spawn_valid && spawn_ready && (LW'(l) == spawn_lane)) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!spawn_done && !valid_q[l][s]) begin
            spawn_done    = 1'b1;
            valid_d[l][s] = 1'b1;
            y_d[l][s]     = '0;
          end
        end
      end
    end
    score_d   = score_q + hit_cnt * hit_val;
    combo_sum = 32'(combo_q) + hit_cnt;
    combo_d   = (combo_sum > 32'h0000_FFFF) ? 16'hFFFF : combo_sum[15:0];
    // A miss anywhere in the cycle wins over that cycle's increments.
    if (|miss_d) combo_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      y_q     <= '0;
      btn_q   <= '0;
      arm_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      btn_q   <= btn;
      arm_q   <= 1'b1;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  always_comb begin
    pix_in_note = '0;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SLOTS; s++)
        if (valid_q[l][s] && (32'(pix_y) >= 32'(y_q[l][s])) &&
            (32'(pix_y) < (32'(y_q[l][s]) + 32'(NOTE_H))))
          pix_in_note[l] = 1'b1;
  end

  assign hit   = hit_q;
  assign miss  = miss_q;
  assign score = score_q;
  assign combo = combo_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Testbench for note_lane_engine: directed scenarios plus a random phase.
// A note-list model inside the bench is checked against the DUT every cycle.
module tb_note_lane_engine;
  localparam int LANES = 4, SLOTS = 8, Y_W = 10, SCREEN_H = 480, NOTE_H = 50;
  localparam int HIT_Y = 350, HIT_H = 20, SPEED = 1, POINTS = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             tick = 1'b0;
  logic             spawn_valid = 1'b0;
  logic [1:0]       spawn_lane = '0;
  logic             spawn_ready;
  logic [LANES-1:0] btn = '0;
  logic [Y_W-1:0]   pix_y = '0;
  logic [LANES-1:0] pix_in_note, hit, miss;
  logic [31:0]      score;
  logic [15:0]      combo;

  note_lane_engine #(
    .LANES(LANES), .SLOTS(SLOTS), .Y_W(Y_W), .SCREEN_H(SCREEN_H), .NOTE_H(NOTE_H),
    .HIT_Y(HIT_Y), .HIT_H(HIT_H), .SPEED(SPEED), .POINTS(POINTS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .btn(btn), .pix_y(pix_y),
    .pix_in_note(pix_in_note), .hit(hit), .miss(miss), .score(score), .combo(combo)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a plain list of notes per lane
  bit               m_valid[LANES][SLOTS];
  int               m_y[LANES][SLOTS];
  logic [31:0]      m_score;
  int               m_combo;
  logic [LANES-1:0] m_btn_prev, e_hit, e_miss;
  bit               m_arm;

  function automatic bit m_hittable(input int y);
    return (y < HIT_Y + HIT_H) && (y + NOTE_H > HIT_Y);
  endfunction

  function automatic int m_hit_value(input int c);
    int k;
    k = 1 + c / 8;
    if (k > 4) k = 4;
`ifdef NOTE_LANE_COMBO_MULT_EN
    return POINTS * k;
`else
    return POINTS;
`endif
  endfunction

  function automatic bit m_ready(input int lane);
    for (int i = 0; i < SLOTS; i++) if (!m_valid[lane][i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [LANES-1:0] m_pix(input int py);
    logic [LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      for (int i = 0; i < SLOTS; i++)
        if (m_valid[l][i] && py >= m_y[l][i] && py < m_y[l][i] + NOTE_H) r[l] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < LANES; l++)
      for (int i = 0; i < SLOTS; i++) begin
        m_valid[l][i] = 1'b0;
        m_y[l][i]     = 0;
      end
    m_score = '0; m_combo = 0; m_btn_prev = '0; e_hit = '0; e_miss = '0; m_arm = 1'b0;
  endtask

  task automatic model_step();
    logic [LANES-1:0] pr;
    int sp, nh, s;
    pr = btn & ~m_btn_prev & {LANES{m_arm}};
    sp = -1;
    if (spawn_valid)
      for (int i = 0; i < SLOTS; i++) if (sp < 0 && !m_valid[spawn_lane][i]) sp = i;
    e_hit = '0; e_miss = '0; nh = 0;
    for (int l = 0; l < LANES; l++) begin
      if (pr[l]) begin
        s = -1;
        for (int i = 0; i < SLOTS; i++)
          if (s < 0 && m_valid[l][i] && m_hittable(m_y[l][i])) s = i;
        if (s >= 0) begin
          m_valid[l][s] = 1'b0; e_hit[l] = 1'b1; nh++;
        end else e_miss[l] = 1'b1;
      end
    end
    if (tick)
      for (int l = 0; l < LANES; l++)
        for (int i = 0; i < SLOTS; i++)
          if (m_valid[l][i]) begin
            m_y[l][i] += SPEED;
            if (m_y[l][i] >= SCREEN_H) begin
              m_valid[l][i] = 1'b0; e_miss[l] = 1'b1;
            end
          end
    if (sp >= 0) begin
      m_valid[spawn_lane][sp] = 1'b1; m_y[spawn_lane][sp] = 0;
    end
    m_score = m_score + 32'(nh * m_hit_value(m_combo));
    m_combo = m_combo + nh;
    if (m_combo > 65535) m_combo = 65535;
    if (e_miss != '0) m_combo = 0;
    m_btn_prev = btn;
    m_arm = 1'b1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_clear();
    else model_step();
  end

  // every-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("hit", 32'(hit), 32'(e_hit));
    chk("miss", 32'(miss), 32'(e_miss));
    chk("score", score, m_score);
    chk("combo", 32'(combo), 32'(m_combo));
    chk("spawn_ready", 32'(spawn_ready), 32'(m_ready(int'(spawn_lane))));
    chk("pix_in_note", 32'(pix_in_note), 32'(m_pix(int'(pix_y))));
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick = 1'b0; spawn_valid = 1'b0; btn = '0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  int cnt;

  initial begin
    do_reset();
    chk("rst_score", score, 32'd0);
    chk("rst_combo", 32'(combo), 32'd0);
    chk("rst_ready", 32'(spawn_ready), 32'd1);

    // fill lane 0: the ninth spawn is ignored
    spawn_valid = 1'b1; spawn_lane = 2'd0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 7) chk("fill_ready7", 32'(spawn_ready), 32'd1);
      if (i == 8) chk("fill_ready8", 32'(spawn_ready), 32'd0);
    end
    spawn_valid = 1'b0; pix_y = '0;
    step();
    chk("fill_pix", 32'(pix_in_note), 32'h1);

    // single note in lane 1 falls off the screen
    do_reset();
    spawn_valid = 1'b1; spawn_lane = 2'd1;
    step();
    spawn_valid = 1'b0; tick = 1'b1; cnt = 0;
    for (int i = 0; i < 479; i++) begin
      step();
      if (miss[1]) cnt++;
    end
    tick = 1'b0; pix_y = 10'd479;
    step();
    chk("exp_early_miss", 32'(cnt), 32'd0);
    chk("exp_pix479", 32'(pix_in_note), 32'h2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("exp_miss", 32'(miss), 32'h2);
    chk("exp_combo", 32'(combo), 32'd0);
    step();
    chk("exp_miss_once", 32'(miss), 32'h0);
    chk("exp_freed", 32'(pix_in_note), 32'h0);

    // lane 2 note at y = 310 is hit
    do_reset();
    spawn_valid = 1'b1; spawn_lane = 2'd2;
    step();
    spawn_valid = 1'b0; tick = 1'b1;
    repeat (310) step();
    tick = 1'b0; btn[2] = 1'b1;
    step();
    chk("hit2_pulse", 32'(hit), 32'h4);
    chk("hit2_score", score, 32'd10);
    chk("hit2_combo", 32'(combo), 32'd1);
    btn[2] = 1'b0;
    step();
    chk("hit2_once", 32'(hit), 32'h0);

    // five hits in lane 0, then a press on an empty lane 3
    do_reset();
    spawn_valid = 1'b1; spawn_lane = 2'd0;
    repeat (5) step();
    spawn_valid = 1'b0; tick = 1'b1;
    repeat (340) step();
    tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b1; step();
      btn[0] = 1'b0; step();
    end
    chk("combo5", 32'(combo), 32'd5);
    chk("score50", score, 32'd50);
    btn[3] = 1'b1;
    step();
    chk("miss3_pulse", 32'(miss), 32'h8);
    chk("miss3_combo", 32'(combo), 32'd0);
    chk("miss3_score", score, 32'd50);
    btn[3] = 1'b0;
    step();

    // reset while notes are live and btn[0] is held
    spawn_valid = 1'b1; spawn_lane = 2'd1;
    step();
    spawn_valid = 1'b0; pix_y = '0; btn[0] = 1'b1;
    step();
    chk("pre_rst_pix", 32'(pix_in_note), 32'h2);
    reset_n = 1'b0;
    #1;
    chk("rst_pix_now", 32'(pix_in_note), 32'h0);
    chk("rst_score_now", score, 32'd0);
    step();
    reset_n = 1'b1; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ((hit | miss) != '0) cnt++;
    end
    chk("held_no_pulse", 32'(cnt), 32'd0);
    btn[0] = 1'b0;
    step();
    btn[0] = 1'b1;
    step();
    chk("repress_miss", 32'(miss), 32'h1);
    btn[0] = 1'b0;
    step();

    // random phase
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      spawn_valid = ($urandom_range(0, 7) == 0);
      spawn_lane  = 2'($urandom_range(0, 3));
      tick        = ($urandom_range(0, 3) != 0);
      pix_y       = 10'($urandom_range(0, 1023));
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 15) == 0) btn[l] = ~btn[l];
      step();
    end
    spawn_valid = 1'b0; tick = 1'b0; btn = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
